// File: rtl/pad_bidir_pkg.sv
// Shared types and sizing helpers for the bidirectional pad scheduler.
package pad_bidir_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StTurn,
        StSample
    } state_e;

    // Wide enough for the longest phase count without wrapping.
    function automatic int unsigned cnt_width(input int unsigned hold,
                                              input int unsigned turn,
                                              input int unsigned sync);
        int unsigned m;
        m = hold;
        if (turn > m) m = turn;
        if (sync + 1 > m) m = sync + 1;
        return $clog2(m + 1);
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pad_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr_i wins.
module pad_rr_arb
    import pad_bidir_pkg::*;
#(
    parameter int unsigned NumReq = 2,
    parameter int unsigned IdxW   = idx_width(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o,
    output logic              valid_o
);

    logic [IdxW-1:0] cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = IdxW'((32'(ptr_i) + i) % NumReq);
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pad_bidir_sched.sv
// Arbitrates a shared bidirectional pad group between requesters, enforcing
// drive hold, release turnaround and a synchronised sample path.
module pad_bidir_sched
    import pad_bidir_pkg::*;
#(
    parameter int unsigned NumReq     = 2,
    parameter int unsigned Width      = 8,
    parameter int unsigned HoldCycles = 2,
    parameter int unsigned TurnCycles = 1,
    parameter int unsigned SyncStages = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NumReq-1:0]              req_i,
    input  logic [NumReq-1:0]              we_i,
    input  logic [NumReq-1:0][Width-1:0]   wdata_i,
    output logic [NumReq-1:0]              gnt_o,
    output logic [Width-1:0]               rdata_o,
    output logic [NumReq-1:0]              rvalid_o,
    output logic [Width-1:0]               pad_din_o,
    output logic [Width-1:0]               pad_oen_o,
    input  logic [Width-1:0]               pad_dout_i
);

    localparam int unsigned IdxW = idx_width(NumReq);
    localparam int unsigned CntW = cnt_width(HoldCycles, TurnCycles, SyncStages);

    localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);
    localparam logic [CntW-1:0] TurnLast = CntW'((TurnCycles > 0) ? TurnCycles - 1 : 0);
    localparam logic [CntW-1:0] SampLast = CntW'(SyncStages);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [NumReq-1:0] gnt_q, gnt_d;
    logic [NumReq-1:0] rvalid_q, rvalid_d;
    logic [Width-1:0]  rdata_q, rdata_d;
    logic [Width-1:0]  din_q, din_d;
    logic [Width-1:0]  oen_q, oen_d;

    logic [Width-1:0]  sync_q [SyncStages];

    logic [NumReq-1:0] arb_gnt;
    logic [IdxW-1:0]   arb_idx;
    logic              arb_valid;

    pad_rr_arb #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_arb (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // pad_dout_i is asynchronous to clk_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < SyncStages; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= pad_dout_i;
            for (int unsigned i = 1; i < SyncStages; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CntW'(1);
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        gnt_d    = '0;
        rvalid_d = '0;
        rdata_d  = rdata_q;
        din_d    = din_q;
        oen_d    = oen_q;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (arb_valid) begin
                    gnt_d   = arb_gnt;
                    owner_d = arb_idx;
                    ptr_d   = (arb_idx == IdxW'(NumReq - 1)) ? '0 : arb_idx + IdxW'(1);
                    if (we_i[arb_idx]) begin
                        state_d = StDrive;
                        din_d   = wdata_i[arb_idx];
                        oen_d   = '0;
                    end else begin
                        state_d = StSample;
                    end
                end
            end
            StDrive: begin
                if (cnt_q == HoldLast) begin
                    oen_d   = '1;
                    cnt_d   = '0;
                    state_d = (TurnCycles > 0) ? StTurn : StIdle;
                end
            end
            StTurn: begin
                if (cnt_q == TurnLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            StSample: begin
                if (cnt_q == SampLast) begin
                    rdata_d           = sync_q[SyncStages-1];
                    rvalid_d[owner_q] = 1'b1;
                    cnt_d             = '0;
                    state_d           = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                oen_d   = '1;
            end
        endcase
    end

    // Reset releases the pads on the same edge, aborting any transaction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            ptr_q    <= '0;
            owner_q  <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            din_q    <= '0;
            oen_q    <= '1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            din_q    <= din_d;
            oen_q    <= oen_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign pad_din_o = din_q;
    assign pad_oen_o = oen_q;

endmodule
